// File: rtl/lex_pkg.sv
// Shared encodings for the streaming token lexer: token types, FSM states and
// the ASCII bounds used by the character classifier.
package lex_pkg;

    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [TYPE_W-1:0] {
        TOK_ERR   = 2'd0,
        TOK_IDENT = 2'd1,
        TOK_DEC   = 2'd2,
        TOK_HEX   = 2'd3
    } tok_type_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_IDENT = 3'd1,
        ST_ZERO  = 3'd2,
        ST_DEC   = 3'd3,
        ST_HEXP  = 3'd4,
        ST_HEX   = 3'd5,
        ST_BAD   = 3'd6
    } state_e;

    localparam logic [7:0] ASC_0    = 8'd48;
    localparam logic [7:0] ASC_9    = 8'd57;
    localparam logic [7:0] ASC_UC_A = 8'd65;
    localparam logic [7:0] ASC_UC_F = 8'd70;
    localparam logic [7:0] ASC_UC_X = 8'd88;
    localparam logic [7:0] ASC_UC_Z = 8'd90;
    localparam logic [7:0] ASC_US   = 8'd95;
    localparam logic [7:0] ASC_LC_A = 8'd97;
    localparam logic [7:0] ASC_LC_F = 8'd102;
    localparam logic [7:0] ASC_LC_X = 8'd120;
    localparam logic [7:0] ASC_LC_Z = 8'd122;

endpackage

// File: rtl/lex_token_fsm_if.sv
// Char-in / token-out bundle between the char source, the lexer and the token
// consumer; master drives characters, slave is the lexer.
interface lex_token_fsm_if
    import lex_pkg::*;
#(
    parameter int unsigned LEN_W = 5,
    parameter int unsigned CNT_W = 8
) ();

    logic             in_valid;
    logic [7:0]       char;
    logic             tok_valid;
    tok_type_e        tok_type;
    logic [LEN_W-1:0] tok_len;
    logic             id_ends_digit;
    logic [CNT_W-1:0] tok_count;

    modport master (
        output in_valid, char,
        input  tok_valid, tok_type, tok_len, id_ends_digit, tok_count
    );

    modport slave (
        input  in_valid, char,
        output tok_valid, tok_type, tok_len, id_ends_digit, tok_count
    );

endinterface

// File: rtl/lex_char_class.sv
// Combinational ASCII classifier; anything neither digit nor alpha is a
// delimiter.
module lex_char_class
    import lex_pkg::*;
#(
    parameter bit ALLOW_UNDERSCORE = 1'b1
) (
    input  logic [7:0] char,
    output logic       is_digit,
    output logic       is_alpha,
    output logic       is_hexd,
    output logic       is_x,
    output logic       is_other
);

    logic is_upper;
    logic is_lower;
    logic is_under;

    assign is_upper = (char >= ASC_UC_A) && (char <= ASC_UC_Z);
    assign is_lower = (char >= ASC_LC_A) && (char <= ASC_LC_Z);
    assign is_under = ALLOW_UNDERSCORE && (char == ASC_US);

    assign is_digit = (char >= ASC_0) && (char <= ASC_9);
    assign is_alpha = is_upper || is_lower || is_under;
    assign is_hexd  = is_digit
                   || ((char >= ASC_UC_A) && (char <= ASC_UC_F))
                   || ((char >= ASC_LC_A) && (char <= ASC_LC_F));
    assign is_x     = (char == ASC_UC_X) || (char == ASC_LC_X);
    assign is_other = !(is_digit || is_alpha);

endmodule

// File: rtl/lex_token_fsm.sv
// Streaming lexer: classifies identifiers, decimal and 0x-hex literals and
// pulses one registered token report per delimiter.
module lex_token_fsm
    import lex_pkg::*;
#(
    parameter int unsigned MAX_LEN          = 16,
    parameter int unsigned LEN_W            = 5,
    parameter int unsigned CNT_W            = 8,
    parameter bit          ALLOW_UNDERSCORE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    lex_token_fsm_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;

    logic             tok_valid_q;
    tok_type_e        tok_type_q;
    logic [LEN_W-1:0] tok_len_q;
    logic             id_q;
    logic             id_d;
    logic [CNT_W-1:0] tok_count_q;

    logic             emit_c;
    tok_type_e        emit_type_c;

    logic is_digit;
    logic is_alpha;
    logic is_hexd;
    logic is_x;
    logic is_other;

    lex_char_class #(
        .ALLOW_UNDERSCORE (ALLOW_UNDERSCORE)
    ) u_class (
        .char     (bus.char),
        .is_digit (is_digit),
        .is_alpha (is_alpha),
        .is_hexd  (is_hexd),
        .is_x     (is_x),
        .is_other (is_other)
    );

    // State, length and report registers; reset drops any token in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= TOK_ERR;
            tok_len_q   <= '0;
            id_q        <= 1'b0;
            tok_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tok_valid_q <= emit_c;
            id_q        <= id_d;
            if (emit_c) begin
                tok_type_q <= emit_type_c;
                tok_len_q  <= len_q;
                if (emit_type_c != TOK_ERR) begin
                    tok_count_q <= tok_count_q + CNT_W'(1);
                end
            end
        end
    end

    // Next state and length; an over-long token parks in BAD with len saturated.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        if (bus.in_valid) begin
            if (is_other) begin
                state_d = ST_IDLE;
                len_d   = '0;
            end else if (state_q == ST_IDLE) begin
                len_d = LEN_W'(1);
                if (is_alpha) begin
                    state_d = ST_IDENT;
                end else if (bus.char == ASC_0) begin
                    state_d = ST_ZERO;
                end else begin
                    state_d = ST_DEC;
                end
            end else if (len_q >= LEN_W'(MAX_LEN)) begin
                state_d = ST_BAD;
            end else begin
                len_d = len_q + LEN_W'(1);
                unique case (state_q)
                    ST_IDENT: state_d = ST_IDENT;
                    ST_ZERO:  state_d = is_x ? ST_HEXP : (is_digit ? ST_DEC : ST_BAD);
                    ST_DEC:   state_d = is_digit ? ST_DEC : ST_BAD;
                    ST_HEXP,
                    ST_HEX:   state_d = is_hexd ? ST_HEX : ST_BAD;
                    default:  state_d = ST_BAD;
                endcase
            end
        end
    end

    // Emission decode and the identifier-ends-in-digit flag.
    always_comb begin
        emit_c      = 1'b0;
        emit_type_c = TOK_ERR;
        id_d        = id_q;
        if (bus.in_valid) begin
            emit_c = is_other && (state_q != ST_IDLE);
            id_d   = (state_d == ST_IDENT) && is_digit;
            unique case (state_q)
                ST_IDENT:       emit_type_c = TOK_IDENT;
                ST_ZERO, ST_DEC: emit_type_c = TOK_DEC;
                ST_HEX:         emit_type_c = TOK_HEX;
                default:        emit_type_c = TOK_ERR;
            endcase
        end
    end

    assign bus.tok_valid     = tok_valid_q;
    assign bus.tok_type      = tok_type_q;
    assign bus.tok_len       = tok_len_q;
    assign bus.id_ends_digit = id_q;
    assign bus.tok_count     = tok_count_q;

endmodule

// File: tb/tb_lex_token_fsm.sv
// Bench for lex_token_fsm: directed vector table, hand-written corner cases and
// a random char stream checked against a token-buffer reference model.
module tb_lex_token_fsm;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned CNT_W   = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lex_token_fsm_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus  ();
    lex_token_fsm_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus0 ();

    lex_token_fsm #(
        .MAX_LEN (MAX_LEN), .LEN_W (LEN_W), .CNT_W (CNT_W), .ALLOW_UNDERSCORE (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    lex_token_fsm #(
        .MAX_LEN (MAX_LEN), .LEN_W (LEN_W), .CNT_W (CNT_W), .ALLOW_UNDERSCORE (1'b0)
    ) dut_nous (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer the token text, classify it whole at the delimiter.
    logic [7:0]       tokq[$];
    logic             m_tv;
    logic [1:0]       m_type;
    logic [LEN_W-1:0] m_len;
    logic             m_id;
    logic [CNT_W-1:0] m_cnt;

    function automatic bit m_digit(input logic [7:0] c);
        return (c >= 8'd48) && (c <= 8'd57);
    endfunction

    function automatic bit m_alpha(input logic [7:0] c);
        return ((c >= 8'd65) && (c <= 8'd90)) || ((c >= 8'd97) && (c <= 8'd122)) || (c == 8'd95);
    endfunction

    function automatic bit m_hexd(input logic [7:0] c);
        return m_digit(c) || ((c >= 8'd65) && (c <= 8'd70)) || ((c >= 8'd97) && (c <= 8'd102));
    endfunction

    function automatic logic [1:0] m_classify();
        int n = tokq.size();
        bit ok = 1'b1;
        if (n > int'(MAX_LEN)) return 2'd0;
        if (m_alpha(tokq[0])) return 2'd1;
        if (tokq[0] == 8'd48 && n >= 2 && (tokq[1] == 8'd120 || tokq[1] == 8'd88)) begin
            if (n == 2) return 2'd0;
            for (int i = 2; i < n; i++) ok = ok && m_hexd(tokq[i]);
            return ok ? 2'd3 : 2'd0;
        end
        for (int i = 0; i < n; i++) ok = ok && m_digit(tokq[i]);
        return ok ? 2'd2 : 2'd0;
    endfunction

    task automatic model_reset();
        tokq.delete();
        m_tv = 1'b0; m_type = '0; m_len = '0; m_id = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] c);
        m_tv = 1'b0;
        if (v) begin
            if (m_digit(c) || m_alpha(c)) begin
                tokq.push_back(c);
                m_id = m_alpha(tokq[0]) && (tokq.size() <= int'(MAX_LEN)) && m_digit(c);
            end else begin
                if (tokq.size() > 0) begin
                    m_tv   = 1'b1;
                    m_type = m_classify();
                    m_len  = LEN_W'((tokq.size() > int'(MAX_LEN)) ? MAX_LEN : tokq.size());
                    if (m_type != 2'd0) m_cnt = m_cnt + CNT_W'(1);
                    tokq.delete();
                end
                m_id = 1'b0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c);
        bus.in_valid = v;
        bus.char     = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        check("tok_valid",     32'(bus.tok_valid),     32'(m_tv));
        check("tok_type",      32'(bus.tok_type),      32'(m_type));
        check("tok_len",       32'(bus.tok_len),       32'(m_len));
        check("id_ends_digit", 32'(bus.id_ends_digit), 32'(m_id));
        check("tok_count",     32'(bus.tok_count),     32'(m_cnt));
    endtask

    // Reset asserted together with a valid char: reset must win.
    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.char     = "a";
        bus0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        check("rst_tok_valid", 32'(bus.tok_valid), 32'd0);
        check("rst_tok_type",  32'(bus.tok_type),  32'd0);
        check("rst_tok_len",   32'(bus.tok_len),   32'd0);
        check("rst_id",        32'(bus.id_ends_digit), 32'd0);
        check("rst_tok_count", 32'(bus.tok_count), 32'd0);
    endtask

    task automatic step0(input logic [7:0] c);
        bus0.in_valid = 1'b1;
        bus0.char     = c;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] c;
        logic       tv;
        logic [1:0] ty;
        logic [4:0] ln;
        logic       id;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] c, input logic tv, input logic [1:0] ty,
                       input logic [4:0] ln, input logic id, input logic [7:0] cnt);
        vec_t e;
        e.v = v; e.c = c; e.tv = tv; e.ty = ty; e.ln = ln; e.id = id; e.cnt = cnt;
        vecs.push_back(e);
    endtask

    task automatic add_run(input string s, input logic [1:0] ty, input logic [4:0] ln, input logic [7:0] cnt);
        for (int i = 0; i < s.len(); i++) add(1'b1, s[i], 1'b0, ty, ln, 1'b0, cnt);
    endtask

    initial begin
        string pool;
        logic [7:0] c;
        logic v;

        reset = 1'b0;
        bus.in_valid = 1'b0;  bus.char = '0;
        bus0.in_valid = 1'b0; bus0.char = '0;
        model_reset();

        // Directed vectors; expectations written from the token rules.
        add(1'b1, "a", 1'b0, 2'd0, 5'd0, 1'b0, 8'd0);
        add(1'b1, "1", 1'b0, 2'd0, 5'd0, 1'b1, 8'd0);
        add(1'b1, "b", 1'b0, 2'd0, 5'd0, 1'b0, 8'd0);
        add(1'b1, "2", 1'b0, 2'd0, 5'd0, 1'b1, 8'd0);
        add(1'b1, " ", 1'b1, 2'd1, 5'd4, 1'b0, 8'd1);
        add_run("0x1F", 2'd1, 5'd4, 8'd1);
        add(1'b1, ";", 1'b1, 2'd3, 5'd4, 1'b0, 8'd2);
        add_run("0", 2'd3, 5'd4, 8'd2);
        add(1'b1, ";", 1'b1, 2'd2, 5'd1, 1'b0, 8'd3);
        add_run("0x", 2'd2, 5'd1, 8'd3);
        add(1'b1, ";", 1'b1, 2'd0, 5'd2, 1'b0, 8'd3);
        add_run("12ab", 2'd0, 5'd2, 8'd3);
        add(1'b1, " ", 1'b1, 2'd0, 5'd4, 1'b0, 8'd3);
        add_run("ab", 2'd0, 5'd4, 8'd3);
        for (int i = 0; i < 3; i++) add(1'b0, "z", 1'b0, 2'd0, 5'd4, 1'b0, 8'd3);
        add_run("c", 2'd0, 5'd4, 8'd3);
        add(1'b1, " ", 1'b1, 2'd1, 5'd3, 1'b0, 8'd4);
        add_run("9", 2'd1, 5'd3, 8'd4);
        add(1'b1, ";", 1'b1, 2'd2, 5'd1, 1'b0, 8'd5);

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].c);
            check($sformatf("vec%0d_tv", i),  32'(bus.tok_valid),     32'(vecs[i].tv));
            check($sformatf("vec%0d_ty", i),  32'(bus.tok_type),      32'(vecs[i].ty));
            check($sformatf("vec%0d_ln", i),  32'(bus.tok_len),       32'(vecs[i].ln));
            check($sformatf("vec%0d_id", i),  32'(bus.id_ends_digit), 32'(vecs[i].id));
            check($sformatf("vec%0d_cnt", i), 32'(bus.tok_count),     32'(vecs[i].cnt));
        end

        // Over-long identifier saturates at MAX_LEN and reports ERR.
        do_reset();
        for (int i = 0; i < int'(MAX_LEN) + 1; i++) step(1'b1, "a");
        step(1'b1, " ");
        check("ovf_tv",  32'(bus.tok_valid), 32'd1);
        check("ovf_ty",  32'(bus.tok_type),  32'd0);
        check("ovf_len", 32'(bus.tok_len),   32'(MAX_LEN));
        check("ovf_cnt", 32'(bus.tok_count), 32'd0);

        // Reset in the middle of a token drops it.
        do_reset();
        step(1'b1, "a"); step(1'b1, "b"); step(1'b1, "c");
        do_reset();
        step(1'b1, " ");
        check("drop_tv",  32'(bus.tok_valid), 32'd0);
        check("drop_ty",  32'(bus.tok_type),  32'd0);
        check("drop_len", 32'(bus.tok_len),   32'd0);
        check("drop_cnt", 32'(bus.tok_count), 32'd0);

        // Without underscore support '_' is a plain delimiter from IDLE.
        step0("_");
        check("us_tv0", 32'(bus0.tok_valid), 32'd0);
        step0("a");
        check("us_tv1", 32'(bus0.tok_valid), 32'd0);
        step0(" ");
        check("us_tv2",  32'(bus0.tok_valid),     32'd1);
        check("us_ty",   32'(bus0.tok_type),      32'd1);
        check("us_len",  32'(bus0.tok_len),       32'd1);
        check("us_id",   32'(bus0.id_ends_digit), 32'd0);
        check("us_cnt",  32'(bus0.tok_count),     32'd1);
        @(posedge clk); #1;
        check("us_pulse", 32'(bus0.tok_valid), 32'd0);

        // Random char stream against the reference model.
        pool = "0123456789abcfxXAFgz_ ;.G";
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) c = 8'($urandom_range(0, 255));
                else c = pool[$urandom_range(0, pool.len() - 1)];
                step(v, c);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
